// File: rtl/spi_slave_if.sv
// SPI mode-0 responder: oversampled sclk/cs/mosi, valid/ready RX and TX word ports.
// Optional SPI_SLV_OVERRUN_EN: a word that completes while rx_data is still unconsumed is dropped.

module spi_slave_if #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_TX     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              tx_underrun,
  output logic              rx_overrun
);

  localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, cs_hist_q, mosi_hist_q;
  logic                   sclk_s, cs_s, sclk_rise, sclk_fall, cs_sel, cs_desel;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   hold_empty_q, hold_empty_d;
  logic                   reload_q, reload_d;
  logic                   miso_q, miso_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   busy_q, busy_d;
  logic                   do_load;
  logic [DATA_W-1:0]      rx_word;
`ifdef SPI_SLV_OVERRUN_EN
  logic                   overrun_q, overrun_d;
`endif

  // Synchroniser chains carry no reset so they track the pins while reset is held;
  // the reset history flops then prevent a stale cs-low from looking like a select.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  always_ff @(posedge clk) begin
    sclk_sync_q <= sclk_sync_d;
    cs_sync_q   <= cs_sync_d;
    mosi_sync_q <= mosi_sync_d;
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_sel    = ~cs_s & cs_hist_q;
  assign cs_desel  = cs_s & ~cs_hist_q;

  // Frame sequencing, shift registers and holding register.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    hold_d       = hold_q;
    hold_empty_d = hold_empty_q;
    reload_d     = reload_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rx_ready;
    underrun_d   = 1'b0;
    busy_d       = ~cs_s;
    miso_d       = 1'b0;
    do_load      = 1'b0;
    rx_word      = {rx_shift_q[DATA_W-2:0], mosi_hist_q};
`ifdef SPI_SLV_OVERRUN_EN
    overrun_d    = 1'b0;
`endif

    if (cs_desel) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      reload_d   = 1'b0;
      tx_shift_d = '0;
      rx_shift_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (cs_sel) state_d = LOAD;
        LOAD: begin
          do_load = 1'b1;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shift_d = rx_word;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              reload_d  = 1'b1;
`ifdef SPI_SLV_OVERRUN_EN
              if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
              end else begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
              end
`else
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          if (sclk_fall) begin
            if (reload_q) begin
              do_load  = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_load) begin
      if (!hold_empty_q) begin
        tx_shift_d   = hold_q;
        hold_empty_d = 1'b1;
      end else begin
        tx_shift_d = IDLE_TX;
        underrun_d = 1'b1;
      end
    end

    // Only an empty holding register accepts, so this never races a load from a full one.
    if (hold_empty_q && tx_valid) begin
      hold_d       = tx_data;
      hold_empty_d = 1'b0;
    end

    if (state_d != IDLE) miso_d = tx_shift_d[DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_hist_q  <= 1'b0;
      cs_hist_q    <= 1'b0;
      mosi_hist_q  <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      hold_q       <= '0;
      hold_empty_q <= 1'b1;
      reload_q     <= 1'b0;
      miso_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
      overrun_q    <= 1'b0;
`endif
    end else begin
      sclk_hist_q  <= sclk_s;
      cs_hist_q    <= cs_s;
      mosi_hist_q  <= mosi_sync_q[SYNC_STAGES-1];
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      hold_q       <= hold_d;
      hold_empty_q <= hold_empty_d;
      reload_q     <= reload_d;
      miso_q       <= miso_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      underrun_q   <= underrun_d;
      busy_q       <= busy_d;
`ifdef SPI_SLV_OVERRUN_EN
      overrun_q    <= overrun_d;
`endif
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = hold_empty_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign tx_underrun = underrun_q;
`ifdef SPI_SLV_OVERRUN_EN
  assign rx_overrun  = overrun_q;
`else
  assign rx_overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: a mode-0 master model drives frames, expected words are queued
// from a word-level model and checked by an independent monitor.

module tb_spi_slave_if;

  localparam int unsigned DATA_W = 8;
  localparam logic [7:0]  IDLE_TX = 8'h00;

  logic       clk = 1'b0;
  logic       reset, sclk, cs, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, busy, tx_underrun, rx_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int und_cnt = 0;
  int ovr_cnt = 0;
  int bits_done = 0;

  logic [7:0] exp_rx_q[$];
  bit         rdy_rand  = 1'b0;
  logic       rdy_fixed = 1'b1;

  logic [7:0] f_mosi[4];
  logic [7:0] f_tx[4];
  bit         f_prov[4];
  int         f_n, f_abort;
  bit         f_skip_rx;
  logic [7:0] m_in[4];

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(DATA_W), .SYNC_STAGES(2), .IDLE_TX(IDLE_TX)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: drives rx_ready, then scores the handshake the next posedge will perform.
  always @(negedge clk) begin
    rx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    if (!reset) begin
      if (tx_underrun) und_cnt++;
      if (rx_overrun)  ovr_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_rx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got 0x%0h expected no word at %0t", rx_data, $time);
        end else begin
          chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
        end
      end
    end
  end

  task automatic write_tx(input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready && t < 200) begin
      wclk(1);
      t++;
    end
    chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    wclk(1);
    tx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_miso"},     {31'd0, miso},        32'd0);
    chk({tag, "_tx_ready"}, {31'd0, tx_ready},    32'd1);
    chk({tag, "_rx_valid"}, {31'd0, rx_valid},    32'd0);
    chk({tag, "_rx_data"},  {24'd0, rx_data},     32'd0);
    chk({tag, "_busy"},     {31'd0, busy},        32'd0);
    chk({tag, "_underrun"}, {31'd0, tx_underrun}, 32'd0);
    chk({tag, "_overrun"},  {31'd0, rx_overrun},  32'd0);
  endtask

  // Mode-0 master: data changes on sclk fall, sampled on rise; cs rises together with the final fall.
  task automatic master();
    int total, w, b;
    total = (f_abort > 0) ? f_abort : f_n * DATA_W;
    cs = 1'b0;
    wclk(8);
    for (int i = 0; i < total; i++) begin
      w = i / DATA_W;
      b = DATA_W - 1 - (i % DATA_W);
      mosi = f_mosi[w][b];
      wclk(5);
      sclk = 1'b1;
      m_in[w][b] = miso;
      if (i == 0) chk("busy_in_frame", {31'd0, busy}, 32'd1);
      bits_done++;
      wclk(5);
      sclk = 1'b0;
      if (i == total - 1) cs = 1'b1;
    end
    mosi = 1'b0;
    wclk(10);
  endtask

  // Word-level model: each word slot takes the queued TX word or IDLE_TX (one underrun).
  task automatic do_frame();
    logic [7:0] exp_miso[4];
    int         exp_und, und0, t;
    exp_und = 0;
    for (int k = 0; k < f_n; k++) begin
      exp_miso[k] = f_prov[k] ? f_tx[k] : IDLE_TX;
      if (!f_prov[k]) exp_und++;
      if (f_abort == 0 && !f_skip_rx) exp_rx_q.push_back(f_mosi[k]);
    end
    if (f_prov[0]) write_tx(f_tx[0]);
    und0 = und_cnt;
    bits_done = 0;
    fork
      master();
      begin
        for (int k = 1; k < f_n; k++) begin
          if (f_prov[k]) begin
            int tw;
            tw = 0;
            while (bits_done < DATA_W * (k - 1) + 2 && tw < 2000) begin
              wclk(1);
              tw++;
            end
            write_tx(f_tx[k]);
          end
        end
      end
    join
    if (f_abort == 0) begin
      for (int k = 0; k < f_n; k++) chk("miso_word", {24'd0, m_in[k]}, {24'd0, exp_miso[k]});
    end
    wclk(5);
    chk("underrun_count", und_cnt - und0, exp_und);
    chk("busy_after_frame", {31'd0, busy}, 32'd0);
    if (!f_skip_rx) begin
      t = 0;
      while (exp_rx_q.size() != 0 && t < 300) begin
        wclk(1);
        t++;
      end
      chk("rx_drained", exp_rx_q.size(), 0);
    end
  endtask

  task automatic set_frame(input int n, input int abort_bits, input bit skip_rx);
    f_n = n;
    f_abort = abort_bits;
    f_skip_rx = skip_rx;
    for (int k = 0; k < 4; k++) begin
      f_prov[k] = 1'b0;
      f_tx[k]   = 8'h00;
      f_mosi[k] = 8'h00;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0, und0;
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    wclk(5);
    check_reset_vals("reset");
    reset = 1'b0;
    wclk(5);

    // Basic exchange.
    set_frame(1, 0, 1'b0);
    f_mosi[0] = 8'hA5; f_tx[0] = 8'hF0; f_prov[0] = 1'b1;
    do_frame();

    // Two words with cs held low; second TX word written mid-frame.
    set_frame(2, 0, 1'b0);
    f_mosi[0] = 8'h11; f_mosi[1] = 8'h22;
    f_tx[0] = 8'h3C; f_tx[1] = 8'hC3; f_prov[0] = 1'b1; f_prov[1] = 1'b1;
    do_frame();

    // Underrun.
    set_frame(1, 0, 1'b0);
    f_mosi[0] = 8'h5E;
    do_frame();

    // RX backpressure over two words.
    rdy_fixed = 1'b0;
    wclk(2);
    ovr0 = ovr_cnt;
    set_frame(2, 0, 1'b1);
    f_mosi[0] = 8'hAA; f_mosi[1] = 8'h55;
    do_frame();
    chk("bp_rx_valid", {31'd0, rx_valid}, 32'd1);
`ifdef SPI_SLV_OVERRUN_EN
    chk("bp_rx_data", {24'd0, rx_data}, 32'hAA);
    chk("bp_overrun_count", ovr_cnt - ovr0, 1);
    exp_rx_q.push_back(8'hAA);
`else
    chk("bp_rx_data", {24'd0, rx_data}, 32'h55);
    chk("bp_overrun_count", ovr_cnt - ovr0, 0);
    exp_rx_q.push_back(8'h55);
`endif
    rdy_fixed = 1'b1;
    wclk(5);
    chk("bp_drained", exp_rx_q.size(), 0);
    chk("bp_rx_valid_after", {31'd0, rx_valid}, 32'd0);

    // Abort after 3 bits, then a full frame.
    set_frame(1, 3, 1'b0);
    f_mosi[0] = 8'hFF; f_tx[0] = 8'h77; f_prov[0] = 1'b1;
    do_frame();
    chk("abort_tx_ready", {31'd0, tx_ready}, 32'd1);
    set_frame(1, 0, 1'b0);
    f_mosi[0] = 8'h81; f_tx[0] = 8'h18; f_prov[0] = 1'b1;
    do_frame();

    // Reset mid-frame, then clock more bits with cs still low: they must be ignored.
    write_tx(8'h5A);
    und0 = und_cnt;
    cs = 1'b0;
    wclk(8);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1; wclk(5); sclk = 1'b1; wclk(5); sclk = 1'b0;
    end
    reset = 1'b1;
    wclk(1);
    check_reset_vals("midreset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mosi = i[0]; wclk(5); sclk = 1'b1;
      chk("miso_after_reset", {31'd0, miso}, 32'd0);
      wclk(5); sclk = 1'b0;
      if (i == 4) cs = 1'b1;
    end
    mosi = 1'b0;
    wclk(10);
    chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("reset_no_load", und_cnt - und0, 0);
    set_frame(1, 0, 1'b0);
    f_mosi[0] = 8'h81; f_tx[0] = 8'hE7; f_prov[0] = 1'b1;
    do_frame();

    // Randomised frames with a jittering consumer.
    rdy_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      set_frame(int'($urandom_range(1, 3)), 0, 1'b0);
      for (int k = 0; k < f_n; k++) begin
        f_mosi[k] = 8'($urandom);
        f_tx[k]   = 8'($urandom);
        f_prov[k] = 1'($urandom_range(0, 1));
      end
      do_frame();
    end
    rdy_rand = 1'b0;
    wclk(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI responder (slave) endpoint, mode 0 (CPOL=0, CPHA=0), MSB first. Counterpart to the SPI master in the SPI subsystem.
- Oversamples the external sclk, cs and mosi pins in the system clock domain.
- Deserialises mosi into words delivered on a valid/ready RX port.
- Serialises words taken from a valid/ready TX port onto miso.

Parameters:
- DATA_W, 8: word width in bits.
- SYNC_STAGES, 2: synchroniser flops on sclk, cs and mosi (minimum 2).
- IDLE_TX, 8'h00: word shifted out when no TX word is available (width DATA_W).

Ports:
- clk  input  1  system clock; frequency must be at least 4x sclk.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from master; asynchronous to clk.
- cs  input  1  chip select from master, active-low; asynchronous to clk.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master; driven 0 while deselected.
- tx_data  input  DATA_W  next word to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty; word accepted when tx_valid && tx_ready.
- rx_data  output  DATA_W  last received word.
- rx_valid  output  1  rx_data valid; held until consumed.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- busy  output  1  frame in progress (synchronised cs low).
- tx_underrun  output  1  one-cycle pulse: IDLE_TX was loaded because the holding register was empty.
- rx_overrun  output  1  one-cycle pulse: received word dropped (see Optional Feature).

Behaviour:
- Reset: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, tx_underrun=0, rx_overrun=0. Bit counter, shift registers and holding register cleared; state IDLE.
- Reset mid-frame aborts everything. After reset deasserts, the block waits for a fresh cs falling edge, even if cs is still low.
- Synchronisers: SYNC_STAGES flops plus one history flop per pin. Rise, fall, select and deselect events are detected from the history flop.
- States:
  - IDLE: leaves on the cs falling event.
  - LOAD: one cycle; shift register <= holding register if full (holding then empties), else IDLE_TX with a tx_underrun pulse. miso = shift MSB from the next cycle. Goes to SHIFT.
  - SHIFT: runs until the cs rising event.
  - Any state returns to IDLE on the cs rising event.
- In SHIFT:
  - sclk rise event: rx_shift <= {rx_shift, mosi_sync}; bit_cnt++.
  - When bit_cnt reaches DATA_W: rx_data <= completed word; rx_valid=1 on the following cycle; bit_cnt=0; reload flag set.
  - sclk fall event: if the reload flag is set, reload the shift register exactly as in LOAD (including underrun) and clear the flag; else shift left by one. miso follows the shift MSB one cycle after the event.
- busy = synchronised cs low, independent of state.
- Holding register accepts a word whenever empty, including during a frame.
- tx_valid in the same cycle as a load from an empty holding register: IDLE_TX is loaded with an underrun pulse, and the new word is captured into holding.
- rx_ready in the same cycle as a word completion: completion wins; rx_valid stays 1 with the new data; no overrun.
- cs deasserted mid-word: partial RX bits discarded; the in-flight TX word is lost, not re-queued; bit_cnt=0; miso=0 the cycle after the deselect event; holding register retained.
- Frames longer than DATA_W: continuous back-to-back words, reloaded per word.

Optional Feature:
- Macro: SPI_SLV_OVERRUN_EN.
- Defined: a word completing while rx_valid=1 and not accepted that cycle is dropped. rx_data is unchanged and rx_overrun pulses for one cycle.
- Undefined: the new word overwrites rx_data, rx_valid stays 1, and rx_overrun is tied to 0.

Test Plan:
- Basic exchange (clk 100 MHz, sclk 10 MHz, DATA_W=8): preload tx_data=8'hF0, master sends 8'hA5 -> master receives F0; rx_data=A5 with rx_valid=1 after the 8th rise; tx_underrun never pulses.
- Two-word frame with cs held low: holding preloaded 8'h3C, then 8'hC3 written during the frame; master sends 11,22 -> master reads 3C,C3; slave delivers 11 then 22 with rx_ready tied 1.
- Underrun: no TX word written, IDLE_TX=00 -> miso shifts 00; tx_underrun pulses once at LOAD.
- RX backpressure with rx_ready=0 over two words (AA, 55): with SPI_SLV_OVERRUN_EN, rx_data=AA and one rx_overrun pulse; without it, rx_data=55 and rx_overrun stays 0.
- Abort: cs raised after 3 bits of 8'hFF -> no rx_valid; the next full frame sending 8'h81 yields rx_data=81.
- Reset asserted mid-frame -> all outputs return to reset values on the next clk; the frame is ignored until a new cs falling edge.
